// File: rtl/tanh_neuron_front.sv
// -----------------------------------------------------------------------------
// tanh_neuron_front
//
// Front end for a tanh activation unit. Collects N (input, weight) pairs,
// accumulates their products in unsigned fixed point (Q2.14 operands, Q4.14
// addends), clamps the sum to the tanh series' convergent range, launches one
// tanh operation over a Start/Ready handshake and holds the returned value
// until the consumer acknowledges it.
//
// Parameters
//   N     pairs per neuron, 1..16
//   XMAX  saturation ceiling for the tanh operand, Q2.14 (default 1.5)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   inValid    xIn/wIn valid this cycle
//   inReady    block accepts a pair this cycle
//   xIn, wIn   input sample and weight, unsigned Q2.14
//   tanhX      operand to tanh, held from clamp until result capture
//   tanhStart  one-cycle Start pulse to tanh
//   tanhReady  Ready from tanh
//   tanhR      result bus from tanh
//   outValid   result held and valid
//   outAck     consumer takes the result
//   result     captured tanh output
//   sat        the pre-clamp sum exceeded XMAX for the held result
// -----------------------------------------------------------------------------
module tanh_neuron_front #(
  parameter int          N    = 4,
  parameter logic [15:0] XMAX = 16'h6000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  output logic        inReady,
  input  logic [15:0] xIn,
  input  logic [15:0] wIn,
  output logic [15:0] tanhX,
  output logic        tanhStart,
  input  logic        tanhReady,
  input  logic [15:0] tanhR,
  output logic        outValid,
  input  logic        outAck,
  output logic [15:0] result,
  output logic        sat
);

  // Each addend is below 2^18, so N of them fit in 18+clog2(N) bits.
  localparam int ACC_W = 18 + $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [ACC_W-1:0] XMAX_EXT = ACC_W'(XMAX);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_CLAMP   = 3'd1;
  localparam logic [2:0] ST_LAUNCH  = 3'd2;
  localparam logic [2:0] ST_WAITLO  = 3'd3;
  localparam logic [2:0] ST_WAITHI  = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  logic [2:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_pend;
  logic [31:0]      prod;
  logic [17:0]      addend;
  logic             over;

  // Q2.14 x Q2.14 = Q4.28; dropping 14 fraction bits gives a Q4.14 addend.
  assign prod   = 32'(xIn) * 32'(wIn);
  assign addend = 18'(prod >> 14);
  assign over   = (acc > XMAX_EXT);

  // Handshake outputs are pure state decodes, so they can never glitch wider
  // than one state's duration.
  assign inReady   = (state == ST_COLLECT);
  assign tanhStart = (state == ST_LAUNCH);
  assign outValid  = (state == ST_HOLD);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking writes would let acc/cnt updates race
  // the next-state decision within the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_COLLECT;
      acc      <= '0;
      cnt      <= '0;
      tanhX    <= '0;
      sat_pend <= 1'b0;
      result   <= '0;
      sat      <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (inValid) begin
            acc <= acc + ACC_W'(addend);
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) state <= ST_CLAMP;
          end
        end
        ST_CLAMP: begin
          // tanhX is written only here, so it stays put while tanh samples it.
          tanhX    <= over ? XMAX : acc[15:0];
          sat_pend <= over;
          state    <= ST_LAUNCH;
        end
        ST_LAUNCH: state <= ST_WAITLO;
        ST_WAITLO: begin
          // Ready must first drop so a stale high level is not taken as done.
          if (!tanhReady) state <= ST_WAITHI;
        end
        ST_WAITHI: begin
          if (tanhReady) begin
            result <= tanhR;
            sat    <= sat_pend;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (outAck) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tanh_neuron_front.sv
// -----------------------------------------------------------------------------
// tb_tanh_neuron_front
//
// Bench for tanh_neuron_front. Contains a behavioural tanh unit (drops Ready
// after Start, samples xBus two cycles after Start, returns tanh after a
// programmable latency) and a timestamp-based reference model of the neuron
// front end, compared against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_tanh_neuron_front;

  localparam int          N    = 4;
  localparam logic [15:0] XMAX = 16'h6000;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [15:0] xIn;
  logic [15:0] wIn;
  logic [15:0] tanhX;
  logic        tanhStart;
  logic        tanhReady;
  logic [15:0] tanhR;
  logic        outValid;
  logic        outAck;
  logic [15:0] result;
  logic        sat;

  int n_vec = 0;
  int n_err = 0;

  tanh_neuron_front #(.N(N), .XMAX(XMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .inValid   (inValid),
    .inReady   (inReady),
    .xIn       (xIn),
    .wIn       (wIn),
    .tanhX     (tanhX),
    .tanhStart (tanhStart),
    .tanhReady (tanhReady),
    .tanhR     (tanhR),
    .outValid  (outValid),
    .outAck    (outAck),
    .result    (result),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rounded tanh in Q2.14.
  function automatic logic [15:0] tanh_fn(input logic [15:0] x);
    real xr;
    real r;
    xr = x;
    r  = $tanh(xr / 16384.0) * 16384.0;
    return 16'($rtoi(r + 0.5));
  endfunction

  function automatic int addend_of(input logic [15:0] x, input logic [15:0] w);
    longint p;
    p = longint'(x) * longint'(w);
    return int'(p >> 14);
  endfunction

  // ---------------- behavioural tanh unit ----------------
  int          tanh_lat = 5;   // cycles Ready stays low
  int          t_age;
  bit          t_busy;
  logic [15:0] t_x;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tanhReady <= 1'b1;
      tanhR     <= '0;
      t_busy    <= 1'b0;
      t_age     <= 0;
      t_x       <= '0;
    end else if (tanhStart) begin
      tanhReady <= 1'b0;
      t_busy    <= 1'b1;
      t_age     <= 0;
    end else if (t_busy) begin
      t_age <= t_age + 1;
      if (t_age == 1) t_x <= tanhX;
      if (t_age >= tanh_lat - 1) begin
        tanhReady <= 1'b1;
        tanhR     <= tanh_fn(t_x);
        t_busy    <= 1'b0;
      end
    end
  end

  // ---------------- reference model (timestamps + sums) ----------------
  int          cyc;
  bit          m_open;
  int          m_taken;
  int          m_sum;
  int          m_start_at;
  logic [15:0] m_x_pend;
  bit          m_sat_pend;
  bit          m_wait_lo;
  bit          m_wait_hi;
  logic [15:0] e_x;
  logic [15:0] e_result;
  bit          e_sat;
  bit          e_valid;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc        <= 0;
      m_open     <= 1'b1;
      m_taken    <= 0;
      m_sum      <= 0;
      m_start_at <= -1;
      m_x_pend   <= '0;
      m_sat_pend <= 1'b0;
      m_wait_lo  <= 1'b0;
      m_wait_hi  <= 1'b0;
      e_x        <= '0;
      e_result   <= '0;
      e_sat      <= 1'b0;
      e_valid    <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_open && inValid) begin
        m_sum   <= m_sum + addend_of(xIn, wIn);
        m_taken <= m_taken + 1;
        if (m_taken == N - 1) begin
          m_open     <= 1'b0;
          m_start_at <= cyc + 2;
          m_sat_pend <= (m_sum + addend_of(xIn, wIn)) > int'(XMAX);
          m_x_pend   <= ((m_sum + addend_of(xIn, wIn)) > int'(XMAX)) ?
                        XMAX : 16'(m_sum + addend_of(xIn, wIn));
        end
      end
      if (cyc == m_start_at - 1) e_x <= m_x_pend;
      if (cyc == m_start_at) m_wait_lo <= 1'b1;
      if (m_wait_lo && !tanhReady) begin
        m_wait_lo <= 1'b0;
        m_wait_hi <= 1'b1;
      end
      if (m_wait_hi && tanhReady) begin
        m_wait_hi <= 1'b0;
        e_valid   <= 1'b1;
        e_result  <= tanh_fn(e_x);
        e_sat     <= m_sat_pend;
      end
      if (e_valid && outAck) begin
        e_valid <= 1'b0;
        m_open  <= 1'b1;
        m_taken <= 0;
        m_sum   <= 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("inReady",   32'(inReady),   32'(m_open));
      check("tanhStart", 32'(tanhStart), 32'(cyc == m_start_at));
      check("tanhX",     32'(tanhX),     32'(e_x));
      check("outValid",  32'(outValid),  32'(e_valid));
      check("result",    32'(result),    32'(e_result));
      check("sat",       32'(sat),       32'(e_sat));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] x, input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      xIn     = x;
      wIn     = w;
      inValid = 1'b1;
      step();
    end
    inValid = 1'b0;
  endtask

  task automatic wait_valid(output int starts);
    bit done;
    done   = 1'b0;
    starts = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (outValid) done = 1'b1;
      else begin
        if (tanhStart) starts++;
        step();
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_valid: outValid not seen within 300 cycles");
    end
  endtask

  task automatic ack();
    outAck = 1'b1;
    step();
    outAck = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_inReady"},   32'(inReady),   32'd1);
    check({tag, "_tanhX"},     32'(tanhX),     32'd0);
    check({tag, "_tanhStart"}, 32'(tanhStart), 32'd0);
    check({tag, "_outValid"},  32'(outValid),  32'd0);
    check({tag, "_result"},    32'(result),    32'd0);
    check({tag, "_sat"},       32'(sat),       32'd0);
  endtask

  initial begin
    int starts;
    int busy_cycles;
    bit drained;

    rst     = 1'b0;
    inValid = 1'b0;
    outAck  = 1'b0;
    xIn     = '0;
    wIn     = '0;
    step();
    step();
    check_reset_values("por");
    rst = 1'b1;
    step();

    // Reset mid-COLLECT after two large pairs; they must not leak forward.
    feed(16'h4000, 16'h4000, 2);
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    step();
    rst = 1'b1;
    step();

    // No saturation: 4 x (0.25 * 1.0) = 1.0.
    tanh_lat = 5;
    feed(16'h1000, 16'h4000, N);
    wait_valid(starts);
    check("nosat_tanhX",  32'(tanhX),  32'h4000);
    check("nosat_sat",    32'(sat),    32'd0);
    check("nosat_result", 32'(result), 32'h30BE);
    ack();
    step();

    // Saturation: 4 x (1.0 * 0.5) = 2.0 > 1.5.
    feed(16'h4000, 16'h2000, N);
    wait_valid(starts);
    check("sat_tanhX", 32'(tanhX), 32'h6000);
    check("sat_sat",   32'(sat),   32'd1);
    ack();
    step();

    // Long tanh latency, single Start pulse, then consumer backpressure.
    tanh_lat = 26;
    feed(16'h1000, 16'h4000, N);
    wait_valid(starts);
    check("hs_start_pulses", 32'(starts), 32'd1);
    for (int i = 0; i < 10; i++) step();
    check("bp_outValid", 32'(outValid), 32'd1);
    check("bp_inReady",  32'(inReady),  32'd0);
    check("bp_result",   32'(result),   32'h30BE);
    ack();
    check("bp_outValid_after", 32'(outValid), 32'd0);
    check("bp_inReady_after",  32'(inReady),  32'd1);

    // inValid stays high with large values while busy; none may be absorbed.
    tanh_lat = 4;
    xIn = 16'h1000; wIn = 16'h4000; inValid = 1'b1;
    for (int i = 0; i < N; i++) step();
    xIn = 16'h4000; wIn = 16'h4000;
    wait_valid(starts);
    xIn = 16'h1000; wIn = 16'h4000;
    outAck = 1'b1;
    step();
    outAck = 1'b0;
    for (int i = 0; i < N; i++) step();
    inValid = 1'b0;
    wait_valid(starts);
    check("gap_tanhX", 32'(tanhX), 32'h4000);
    check("gap_sat",   32'(sat),   32'd0);
    ack();

    // Randomized traffic with random tanh latency and random acks.
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) tanh_lat = $urandom_range(3, 12);
      inValid = ($urandom_range(0, 99) < 60);
      xIn = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h1800));
      wIn = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h4000));
      outAck = ($urandom_range(0, 3) == 0);
      step();
    end

    // Drain any neuron still in flight.
    inValid = 1'b0;
    outAck  = 1'b0;
    drained = 1'b0;
    busy_cycles = 0;
    while (!drained && busy_cycles < 300) begin
      if (inReady && !outAck) drained = 1'b1;
      else begin
        outAck = outValid;
        step();
        busy_cycles++;
      end
    end
    if (!drained) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: block did not return to collect within 300 cycles");
    end
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tanh_neuron_front.md
# tanh_neuron_front

Upstream feeder for the `tanh` activation unit. It accepts a stream of N (input, weight) pairs and accumulates their products in unsigned Q2.14 fixed point. It saturates the sum into the convergent range of the tanh series and launches one `tanh` computation over the Start/Ready handshake. It captures the result and holds it on an output port until the consumer acknowledges it.

## Interface
- N, 4: pairs per neuron; legal range 1..16.
- XMAX, 16'h6000: saturation ceiling for the value driven to tanh, Q2.14 (1.5).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- inValid  in  1  xIn/wIn valid this cycle.
- inReady  out  1  block accepts a pair this cycle.
- xIn  in  16  input sample, unsigned Q2.14.
- wIn  in  16  weight, unsigned Q2.14.
- tanhX  out  16  operand to tanh xBus.
- tanhStart  out  1  Start to tanh.
- tanhReady  in  1  Ready from tanh.
- tanhR  in  16  rBus from tanh.
- outValid  out  1  result held and valid.
- outAck  in  1  consumer takes result.
- result  out  16  captured tanh output.
- sat  out  1  the pre-saturation sum exceeded XMAX for the held result.

## Operation
- Product p = xIn*wIn as a 32-bit value; the addend is p[31:14] (18 bits, Q4.14).
- Accumulator acc: 18+clog2(N) bits (min 18), unsigned, cleared on entry to COLLECT. It cannot overflow.
- State COLLECT:
  - inReady=1.
  - A transfer is a cycle with inValid&inReady. It adds the addend to acc and increments cnt.
  - On the N-th transfer, go to CLAMP.
- State CLAMP (1 cycle), inReady=0:
  - tanhX <= (acc > XMAX) ? XMAX : acc[15:0].
  - satReg <= (acc > XMAX).
- State LAUNCH (1 cycle): tanhStart=1. Next state WAITLO.
- State WAITLO: wait for tanhReady==0, then go to WAITHI.
- State WAITHI: wait for tanhReady==1. In that cycle, result <= tanhR and sat <= satReg, then go to HOLD.
- State HOLD:
  - outValid=1.
  - On outAck, outValid drops the next cycle; acc and cnt clear and the block returns to COLLECT.
- tanhX is stable from CLAMP until leaving WAITHI. tanh samples xBus two cycles after Start, so this stability is mandatory.
- While inReady=0, inValid is ignored; no pair is lost or double-counted.
- tanhReady is ignored outside WAITLO/WAITHI.
- A reset (rst low) in any state returns to COLLECT immediately. An in-flight tanh operation is not tracked. The bench resets tanh together with this block.

## Timing
- Reset values:
  - inReady=1 (COLLECT).
  - tanhX=0, tanhStart=0, outValid=0, result=0, sat=0.
  - acc=0, cnt=0.
- A transfer in cycle k is reflected in acc at edge k+1. Back-to-back transfers are at 1 per cycle.
- Timeline after the N-th transfer in cycle t:
  - CLAMP at t+1, LAUNCH at t+2 (tanhStart high exactly one cycle).
  - WAITLO from t+3; tanh drops Ready at t+3.
- result and outValid rise the cycle after tanhReady returns high.
- outAck coincident with outValid rising is honoured. outAck outside HOLD is ignored.
- inReady is 0 from CLAMP through HOLD, and rises the cycle after the accepting outAck.
- tanhStart never exceeds one cycle. One neuron is in flight at a time.

## Test plan
- Reset check: assert rst=0 mid-COLLECT after 2 pairs → all outputs at reset values. The next neuron's sum excludes the earlier pairs.
- No saturation: N=4 pairs xIn=16'h1000, wIn=16'h4000 at 1/cycle → tanhX=16'h4000, sat=0. result equals the tanh model output for 16'h4000 (≈16'h30BE).
- Saturation: N=4 pairs xIn=16'h4000, wIn=16'h2000 → acc=16'h8000, tanhX=16'h6000, sat=1.
- Gapped input: toggle inValid randomly, and hold inValid=1 during CLAMP..HOLD → exactly N pairs are consumed, and extra beats are not absorbed until the next COLLECT.
- Handshake: model a tanh Ready low for 26 cycles → tanhStart is a single 1-cycle pulse, and tanhX is constant from CLAMP to capture. result is captured on Ready's rising edge.
- Backpressure: hold outAck=0 for 10 cycles → result and outValid are stable and inReady=0. Then pulse outAck for 1 cycle → outValid=0 and inReady=1 the next cycle. Back-to-back neurons give correct independent results.
